// File: rtl/lsu_arbiter.sv
// lsu_arbiter: two requester ports sharing one LSU, one transaction outstanding.
// Build option: define LSU_ARB_RR_EN for round-robin arbitration; without it
// p0 has fixed priority over p1.
module lsu_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        p0_cmd_valid_i,
  output logic        p0_cmd_ready_o,
  input  logic [31:0] p0_cmd_addr_i,
  input  logic [31:0] p0_cmd_data_i,
  input  logic        p0_cmd_we_i,
  input  logic [3:0]  p0_cmd_wstrb_i,
  output logic        p0_rsp_valid_o,
  input  logic        p0_rsp_ready_i,
  output logic [31:0] p0_rsp_data_o,

  input  logic        p1_cmd_valid_i,
  output logic        p1_cmd_ready_o,
  input  logic [31:0] p1_cmd_addr_i,
  input  logic [31:0] p1_cmd_data_i,
  input  logic        p1_cmd_we_i,
  input  logic [3:0]  p1_cmd_wstrb_i,
  output logic        p1_rsp_valid_o,
  input  logic        p1_rsp_ready_i,
  output logic [31:0] p1_rsp_data_o,

  output logic        lsu_cmd_valid_o,
  input  logic        lsu_cmd_ready_i,
  output logic [31:0] lsu_cmd_addr_o,
  output logic [31:0] lsu_cmd_data_o,
  output logic        lsu_cmd_we_o,
  output logic [3:0]  lsu_cmd_wstrb_o,

  input  logic        lsu_rsp_valid_i,
  output logic        lsu_rsp_ready_o,
  input  logic [31:0] lsu_rsp_data_i
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CMD  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_e;

  arb_state_e          state_q, state_d;
  logic                grant_q, grant_d;   // 0 = p0, 1 = p1
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic                we_q,    we_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;

  logic                any_req;
  logic                win_sel;            // 1 = p1 wins this cycle
  logic                rsp_done;

  assign any_req  = p0_cmd_valid_i | p1_cmd_valid_i;
  assign rsp_done = (state_q == ARB_RSP) & lsu_rsp_valid_i &
                    (grant_q ? p1_rsp_ready_i : p0_rsp_ready_i);

`ifdef LSU_ARB_RR_EN
  logic prio_q, prio_d;                    // port favoured on a tie

  // Tie-break by pointer; a lone requester always wins.
  always_comb begin
    win_sel = p1_cmd_valid_i & ~p0_cmd_valid_i;
    if (p0_cmd_valid_i & p1_cmd_valid_i) begin
      win_sel = prio_q;
    end
  end

  // Pointer moves to the other port once a transaction completes.
  always_comb begin
    prio_d = prio_q;
    if (rsp_done) begin
      prio_d = ~grant_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  assign win_sel = p1_cmd_valid_i & ~p0_cmd_valid_i;
`endif

  // State, grant and latched command fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      grant_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
    end
  end

  // Next state, command capture and response routing.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    addr_d          = addr_q;
    data_d          = data_q;
    we_d            = we_q;
    wstrb_d         = wstrb_q;
    p0_cmd_ready_o  = 1'b0;
    p1_cmd_ready_o  = 1'b0;
    p0_rsp_valid_o  = 1'b0;
    p1_rsp_valid_o  = 1'b0;
    p0_rsp_data_o   = '0;
    p1_rsp_data_o   = '0;
    lsu_cmd_valid_o = 1'b0;
    lsu_rsp_ready_o = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        // Nothing outstanding: any response seen here is stale and dropped.
        lsu_rsp_ready_o = 1'b1;
        if (any_req) begin
          p0_cmd_ready_o = ~win_sel;
          p1_cmd_ready_o = win_sel;
          grant_d        = win_sel;
          addr_d         = win_sel ? p1_cmd_addr_i  : p0_cmd_addr_i;
          data_d         = win_sel ? p1_cmd_data_i  : p0_cmd_data_i;
          we_d           = win_sel ? p1_cmd_we_i    : p0_cmd_we_i;
          wstrb_d        = win_sel ? p1_cmd_wstrb_i : p0_cmd_wstrb_i;
          state_d        = ARB_CMD;
        end
      end

      ARB_CMD: begin
        lsu_cmd_valid_o = 1'b1;
        if (lsu_cmd_ready_i) begin
          state_d = ARB_RSP;
        end
      end

      ARB_RSP: begin
        if (grant_q) begin
          p1_rsp_valid_o  = lsu_rsp_valid_i;
          p1_rsp_data_o   = lsu_rsp_data_i;
          lsu_rsp_ready_o = p1_rsp_ready_i;
        end else begin
          p0_rsp_valid_o  = lsu_rsp_valid_i;
          p0_rsp_data_o   = lsu_rsp_data_i;
          lsu_rsp_ready_o = p0_rsp_ready_i;
        end
        if (rsp_done) begin
          state_d = ARB_IDLE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign lsu_cmd_addr_o  = addr_q;
  assign lsu_cmd_data_o  = data_q;
  assign lsu_cmd_we_o    = we_q;
  assign lsu_cmd_wstrb_o = wstrb_q;

endmodule

// File: doc/lsu_arbiter.md
LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 Parameters: none; two requester ports (p0, p1) and 32-bit data are fixed.
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 pN_cmd_valid_i  in  1  requester N (N=0,1) command request.
REQ-005 pN_cmd_ready_o  in/out: out  1  one-cycle accept pulse for requester N's command.
REQ-006 pN_cmd_addr_i  in  32  byte address.
REQ-007 pN_cmd_data_i  in  32  write data.
REQ-008 pN_cmd_we_i  in  1  1 = write, 0 = read.
REQ-009 pN_cmd_wstrb_i  in  4  byte write enables.
REQ-010 pN_rsp_valid_o  out  1  response valid to requester N.
REQ-011 pN_rsp_ready_i  in  1  requester N accepts the response.
REQ-012 pN_rsp_data_o  out  32  read data to requester N (copy of lsu_rsp_data_i, gated to 0 when not granted).
REQ-013 lsu_cmd_valid_o / lsu_cmd_ready_i  out/in  1/1  command handshake to the LSU.
REQ-014 lsu_cmd_addr_o, lsu_cmd_data_o  out  32/32  registered command address and data.
REQ-015 lsu_cmd_we_o, lsu_cmd_wstrb_o  out  1/4  registered write flag and byte enables.
REQ-016 lsu_rsp_valid_i / lsu_rsp_ready_o / lsu_rsp_data_i  in/out/in  1/1/32  LSU response channel.

Function
REQ-017 The FSM SHALL have exactly three states: ARB_IDLE, ARB_CMD and ARB_RSP, with exactly one transaction outstanding.
REQ-018 In ARB_IDLE with any pN_cmd_valid_i=1, the block SHALL select a winner, pulse that port's pN_cmd_ready_o for this cycle only, latch its addr/data/we/wstrb and grant index, and move to ARB_CMD on the next edge.
REQ-019 In ARB_CMD, lsu_cmd_valid_o SHALL be 1, with fields held stable; on lsu_cmd_valid_o & lsu_cmd_ready_i the FSM SHALL move to ARB_RSP.
REQ-020 In ARB_RSP: pG_rsp_valid_o = lsu_rsp_valid_i for granted port G only; lsu_rsp_ready_o = pG_rsp_ready_i; the other port's rsp_valid SHALL be 0.
REQ-021 On lsu_rsp_valid_i & lsu_rsp_ready_o in ARB_RSP, the FSM SHALL return to ARB_IDLE and update the priority pointer.
REQ-022 Minimum latency SHALL be: accept in cycle T, LSU command valid T+1, response forwarded combinationally in the same cycle the LSU presents it.
REQ-023 In ARB_IDLE, lsu_rsp_ready_o SHALL be 1 and any lsu_rsp_valid_i SHALL be discarded (stale-response drain after a mid-transaction reset).
REQ-024 pN_cmd_ready_o SHALL be 0 in ARB_CMD and ARB_RSP; requests arriving then wait, with no loss.
REQ-025 Simultaneous requests SHALL be resolved by the priority rule in REQ-031/REQ-032 within the same cycle; the loser's request remains pending.
REQ-026 An undefined state encoding SHALL return to ARB_IDLE on the next edge.

Reset
REQ-027 On rst_i=1 at a clock edge: state = ARB_IDLE, priority pointer = p0, latched command fields = 0, grant = p0.
REQ-028 Outputs following reset: lsu_cmd_valid_o=0, lsu_cmd_* = 0, pN_cmd_ready_o=0, pN_rsp_valid_o=0, pN_rsp_data_o=0, lsu_rsp_ready_o=1.
REQ-029 A reset in ARB_CMD or ARB_RSP SHALL abandon the transaction with no response delivered to either requester.
REQ-030 rst_i SHALL take precedence over every other transition in the same cycle.

Configuration
REQ-031 With LSU_ARB_RR_EN defined: round-robin; after a completed p0 transaction p1 has priority, and after p1 p0 has priority.
REQ-032 Without LSU_ARB_RR_EN: fixed priority; p0 always wins simultaneous requests, and the pointer is unused.

Verification
REQ-033 Single read: p0 read addr 0x40 -> p0_cmd_ready_o pulse cycle T, lsu_cmd_valid_o at T+1 with addr 0x40, we=0; LSU returns 0xDEADBEEF -> p0_rsp_data_o=0xDEADBEEF, p1_rsp_valid_o=0.
REQ-034 Single write: p1 write addr 0x1004, data 0x12345678, wstrb 0xF -> lsu_cmd_we_o=1, lsu_cmd_wstrb_o=0xF, data 0x12345678; response routed only to p1.
REQ-035 Contention, RR build: p0 and p1 request continuously for 4 transactions -> grant order p0,p1,p0,p1; fixed build -> p0,p0,p0,p0.
REQ-036 Backpressure: lsu_cmd_ready_i held 0 for 5 cycles, then p0_rsp_ready_i held 0 for 3 cycles -> command fields stable throughout; no new grant until response handshake completes.
REQ-037 Reset mid-transaction: rst_i asserted in ARB_RSP, LSU later returns data -> ARB_IDLE, stale response drained via lsu_rsp_ready_o=1, no pN_rsp_valid_o pulse; next p1 request is served normally.
